aes_enc_iter: RTL
=================

# aes_enc_iter

Iterative AES-128 encryption core: the forward (cipher) counterpart of the decryption datapath. It accepts a 128-bit plaintext block and a 128-bit cipher key over a valid/ready handshake. It executes FIPS-197 Cipher() at one round per clock with on-the-fly key expansion, and returns the ciphertext over a second valid/ready handshake. It feeds the loopback and known-answer test path alongside the decryption core, using the same byte ordering.

## Interface
- No parameters. Nk=4 and Nr=10 are fixed.
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- din_valid  in  1  plaintext/key offered
- din_ready  out  1  core can accept; high only in IDLE
- din  in  [0:127]  plaintext; din[0:7] is FIPS input byte in0, din[120:127] is in15
- key  in  [0:127]  cipher key, same byte order as din
- dout_valid  out  1  ciphertext available
- dout_ready  in  1  downstream accepts ciphertext
- dout  out  [0:127]  ciphertext, same byte order

## Operation
- Byte j of the state is bits [8*j +: 8]. Column c is bytes 4c..4c+3.
- SubBytes uses 16 forward Sbox instances (d/q port shape identical to InvSbox). Key expansion uses 4 more instances on the last round-key word.
- Registers:
  - st[0:127]: cipher state
  - rk[0:127]: current round key
  - rcon[7:0]
  - rnd[3:0]
  - fsm: IDLE, ROUND, DONE
- IDLE:
  - din_ready=1.
  - On din_valid&din_ready: st<=din^key, rk<=key, rcon<=8'h01, rnd<=1, go ROUND.
  - din and key are sampled only on this edge. Later changes are ignored.
- ROUND, each cycle:
  - nk = next round key. w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - st <= MixColumns(ShiftRows(SubBytes(st))) ^ nk when rnd<10.
  - st <= ShiftRows(SubBytes(st)) ^ nk when rnd==10 (no MixColumns).
  - rk<=nk; rcon<=xtime(rcon), i.e. {rcon[6:0],1'b0}^(rcon[7]?8'h1b:0); rnd<=rnd+1.
  - After rnd==10: go DONE.
- Rcon sequence is 01,02,04,08,10,20,40,80,1b,36. It is never used beyond round 10.
- ShiftRows: row r (byte 4c+r) rotates left by r columns.
- MixColumns: standard GF(2^8) matrix {02 03 01 01}, reduction polynomial 0x11b.
- DONE:
  - dout_valid=1; dout=st, held stable until accepted.
  - On dout_ready: go IDLE next cycle. din_ready is 0 throughout DONE.
- dout is driven from st directly. Its value is undefined (must not be relied on) while dout_valid=0.
- din_valid while not IDLE: ignored, no effect.
- Reset:
  - Asynchronous; takes effect at any point, including mid-round and in DONE.
  - fsm=IDLE, st=0, rk=0, rcon=8'h01, rnd=0.
  - Outputs: dout_valid=0, din_ready=1, dout=0.
  - Any in-flight block is discarded.

## Timing
- Acceptance edge is E0. Rounds complete on edges E1..E10. dout_valid is high from E10 onward, i.e. 10 cycles after acceptance.
- With dout_ready tied high: dout_valid is high for exactly one cycle, and din_ready returns high after E11.
- Minimum issue interval: 12 cycles per block (1 IDLE, 10 ROUND, 1 DONE).
- Backpressure: with dout_ready low, DONE holds indefinitely and dout/dout_valid do not change.
- Critical path: Sbox → MixColumns → XOR with nk, where nk itself passes through the key Sbox. Single cycle, no multicycle paths.

## Test plan
- FIPS-197 App. B:
  - din=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, dout_ready=1.
  - Required: dout=3925841d02dc09fbdc118597196a0b32 with dout_valid rising exactly 10 cycles after acceptance.
  - Required: intermediate rk after E10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1:
  - din=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f.
  - Required: dout=69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure:
  - Run the App. B vector with dout_ready=0 for 20 cycles after dout_valid, then 1.
  - Required: dout stable and din_ready=0 throughout; a single handshake; din_ready=1 on the following cycle.
- Input stability:
  - Change din/key and pulse din_valid during ROUND.
  - Required: result still equals the vector accepted at E0; the second request is not accepted until IDLE.
- Back-to-back with the decryption core:
  - Encrypt 8 random blocks/keys at full rate, decrypt each result.
  - Required: original plaintext recovered; issue interval exactly 12 cycles.
- Reset mid-operation:
  - Assert rst asynchronously after E5.
  - Required: dout_valid=0 and din_ready=1 immediately; the next App. C.1 block produces the correct ciphertext.

Source files
------------

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 cipher, one round per clock with on-the-fly key expansion.
// Byte j of every 128-bit vector is bits [8*j +: 8]; byte 0 is FIPS byte in0.

module aes_sbox (
   input  logic [7:0] d,
   output logic [7:0] q
);
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign q = SBOX[{d, 3'b000} +: 8];
endmodule

module aes_enc_iter (
   input  logic           clk,
   input  logic           rst,
   input  logic           din_valid,
   output logic           din_ready,
   input  logic [0:127]   din,
   input  logic [0:127]   key,
   output logic           dout_valid,
   input  logic           dout_ready,
   output logic [0:127]   dout
);
   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t       state, state_nx;
   logic [0:127] st, rk, nk, sr_flat, mc, st_nx;
   logic [7:0]   rcon;
   logic [3:0]   rnd;
   logic [7:0]   sb [16];
   logic [7:0]   sr [16];
   logic [7:0]   kq [4];
   logic [31:0]  w0, w1, w2, w3;
   logic         accept, last;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   for (genvar j = 0; j < 16; j++) begin : g_sb
      aes_sbox u_sb (.d(st[8*j +: 8]), .q(sb[j]));
   end

   // Key Sboxes see bytes 12..15 of w3; RotWord is applied on their outputs.
   for (genvar i = 0; i < 4; i++) begin : g_ks
      aes_sbox u_ks (.d(rk[96 + 8*i +: 8]), .q(kq[i]));
   end

   always_comb begin
      w0 = rk[0:31]  ^ {kq[1] ^ rcon, kq[2], kq[3], kq[0]};
      w1 = rk[32:63] ^ w0;
      w2 = rk[64:95] ^ w1;
      w3 = rk[96:127] ^ w2;
      nk = {w0, w1, w2, w3};
   end

   always_comb begin
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            sr[4*c + r] = sb[4*((c + r) % 4) + r];
         end
      end
      sr_flat = '0;
      for (int unsigned j = 0; j < 16; j++) begin
         sr_flat[8*j +: 8] = sr[j];
      end
      mc = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         mc[32*c +: 32] = {
            xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3],
            sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3],
            sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3],
            xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3])};
      end
   end

   assign last   = (rnd == 4'd10);
   assign st_nx  = (last ? sr_flat : mc) ^ nk;
   assign accept = din_valid && (state == IDLE);
   assign dout   = st;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      din_ready  = 1'b0;
      dout_valid = 1'b0;
      case (state)
         IDLE: begin
            din_ready = 1'b1;
            if (din_valid) state_nx = ROUND;
         end
         ROUND: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            dout_valid = 1'b1;
            if (dout_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st   <= '0;
         rk   <= '0;
         rcon <= 8'h01;
         rnd  <= '0;
      end else if (accept) begin
         st   <= din ^ key;
         rk   <= key;
         rcon <= 8'h01;
         rnd  <= 4'd1;
      end else if (state == ROUND) begin
         st   <= st_nx;
         rk   <= nk;
         rcon <= xtime(rcon);
         rnd  <= rnd + 4'd1;
      end
   end
endmodule
